// File: rtl/brc_pkg.sv
// Shared types and helpers for the iterative branch comparator.
package brc_pkg;

    // RISC-V branch funct3 encodings handled by the comparator.
    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } br_op_e;

    // Control states of the chunked compare.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } brc_state_e;

    // Signed ops compare with the sign bit flipped in both operands.
    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == BR_BLT) || (op == BR_BGE);
    endfunction

    // 010 and 011 are not branch encodings.
    function automatic logic op_is_illegal(input logic [2:0] op);
        return (op == 3'b010) || (op == 3'b011);
    endfunction

    // Branch decision from the compare flags; illegal codes never branch.
    function automatic logic br_taken(input logic [2:0] op, input logic less,
                                      input logic equal);
        case (op)
            BR_BEQ:  return equal;
            BR_BNE:  return !equal;
            BR_BLT:  return less;
            BR_BLTU: return less;
            BR_BGE:  return !less;
            BR_BGEU: return !less;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/brc_chunk_cmp.sv
// Combinational unsigned compare of one CHUNK-bit slice.
module brc_chunk_cmp #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             lt,
    output logic             eq
);

    // Plain magnitude and equality compare of the selected slice.
    assign lt = (a < b);
    assign eq = (a == b);

endmodule

// File: rtl/brc_iter.sv
// Multi-cycle branch comparator: walks CHUNK-bit slices from the MSB down,
// optionally stopping at the first differing slice.
//
// Handshakes: a request moves on a cycle where i_valid && o_ready; a result
// is released on a cycle where o_valid && i_ready. o_ready is high only in
// IDLE and o_valid only in DONE, so accept and release never share a cycle.
module brc_iter
    import brc_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int CHUNK      = 8,
    parameter int EARLY_EXIT = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_rs1_data,
    input  logic [WIDTH-1:0] i_rs2_data,
    input  logic [2:0]       i_funct3,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_br_less,
    output logic             o_br_equal,
    output logic             o_br_taken,
    output logic             o_illegal,
    output logic [1:0]       o_dbg_state
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    if (WIDTH < 2 || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("brc_iter: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    brc_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       op_q;
    logic             diff_q, diff_d;
    logic             lt_q, lt_d;
    logic             accept, finish;
    logic [CHUNK-1:0] chunk_a, chunk_b;
    logic             chunk_lt, chunk_eq;

    assign chunk_a = a_q[idx_q*CHUNK +: CHUNK];
    assign chunk_b = b_q[idx_q*CHUNK +: CHUNK];

    brc_chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
        .a  (chunk_a),
        .b  (chunk_b),
        .lt (chunk_lt),
        .eq (chunk_eq)
    );

    assign o_ready     = (state_q == IDLE);
    assign o_valid     = (state_q == DONE);
    assign o_dbg_state = state_q;

    // Next state, chunk index and first-difference tracking.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        diff_d  = diff_q;
        lt_d    = lt_q;
        accept  = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    accept  = 1'b1;
                    state_d = CMP;
                    idx_d   = IDX_W'(N - 1);
                    diff_d  = 1'b0;
                    lt_d    = 1'b0;
                end
            end
            CMP: begin
                // Only the most significant differing chunk decides "less".
                if (!diff_q && !chunk_eq) begin
                    diff_d = 1'b1;
                    lt_d   = chunk_lt;
                end
                if ((EARLY_EXIT != 0) && !diff_q && !chunk_eq) begin
                    finish = 1'b1;
                end else if (idx_q == '0) begin
                    finish = 1'b1;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
                if (finish) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand capture, compare progress and registered result flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            idx_q      <= '0;
            diff_q     <= 1'b0;
            lt_q       <= 1'b0;
            o_br_less  <= 1'b0;
            o_br_equal <= 1'b0;
            o_br_taken <= 1'b0;
            o_illegal  <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            diff_q <= diff_d;
            lt_q   <= lt_d;
            if (accept) begin
                a_q  <= i_rs1_data ^ (op_is_signed(i_funct3) ? MSB_MASK : '0);
                b_q  <= i_rs2_data ^ (op_is_signed(i_funct3) ? MSB_MASK : '0);
                op_q <= i_funct3;
            end
            if (finish) begin
                o_br_less  <= lt_d;
                o_br_equal <= !diff_d;
                o_br_taken <= br_taken(op_q, lt_d, !diff_d);
                o_illegal  <= op_is_illegal(op_q);
            end
        end
    end

endmodule

// File: tb/tb_brc_iter.sv
// Self-checking bench for brc_iter: three configurations (32/8 early exit,
// 32/8 fixed latency, 64/16 early exit) share clock, reset and operand buses.
module tb_brc_iter;
    import brc_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]  valid_in   = '0;
    logic        cons_ready = 1'b0;
    logic [2:0]  f3         = '0;
    logic [63:0] rs1        = '0;
    logic [63:0] rs2        = '0;

    logic [2:0] rdy, vld, less, eq, tkn, ill;
    logic [1:0] st [3];

    int checks   = 0;
    int failures = 0;
    logic [3:0] exp_q[$];
    int         lat_q[$];

    brc_iter #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1)) u_ee (
        .i_clk(clk), .i_rst(rst), .i_valid(valid_in[0]), .o_ready(rdy[0]),
        .i_rs1_data(rs1[31:0]), .i_rs2_data(rs2[31:0]), .i_funct3(f3),
        .o_valid(vld[0]), .i_ready(cons_ready), .o_br_less(less[0]),
        .o_br_equal(eq[0]), .o_br_taken(tkn[0]), .o_illegal(ill[0]),
        .o_dbg_state(st[0])
    );

    brc_iter #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(0)) u_fx (
        .i_clk(clk), .i_rst(rst), .i_valid(valid_in[1]), .o_ready(rdy[1]),
        .i_rs1_data(rs1[31:0]), .i_rs2_data(rs2[31:0]), .i_funct3(f3),
        .o_valid(vld[1]), .i_ready(cons_ready), .o_br_less(less[1]),
        .o_br_equal(eq[1]), .o_br_taken(tkn[1]), .o_illegal(ill[1]),
        .o_dbg_state(st[1])
    );

    brc_iter #(.WIDTH(64), .CHUNK(16), .EARLY_EXIT(1)) u_w64 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid_in[2]), .o_ready(rdy[2]),
        .i_rs1_data(rs1), .i_rs2_data(rs2), .i_funct3(f3),
        .o_valid(vld[2]), .i_ready(cons_ready), .o_br_less(less[2]),
        .o_br_equal(eq[2]), .o_br_taken(tkn[2]), .o_illegal(ill[2]),
        .o_dbg_state(st[2])
    );

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int width_of(input int inst);
        return (inst == 2) ? 64 : 32;
    endfunction

    function automatic int chunk_of(input int inst);
        return (inst == 2) ? 16 : 8;
    endfunction

    // {illegal, taken, equal, less}
    function automatic logic [3:0] model_flags(input int inst, input logic [2:0] op,
                                               input logic [63:0] a, input logic [63:0] b);
        logic lt, e, t, il, sgn;
        sgn = (op == 3'b100) || (op == 3'b101);
        if (width_of(inst) == 32) begin
            e  = (a[31:0] == b[31:0]);
            lt = sgn ? ($signed(a[31:0]) < $signed(b[31:0])) : (a[31:0] < b[31:0]);
        end else begin
            e  = (a == b);
            lt = sgn ? ($signed(a) < $signed(b)) : (a < b);
        end
        il = (op == 3'b010) || (op == 3'b011);
        case (op)
            3'b000:         t = e;
            3'b001:         t = !e;
            3'b100, 3'b110: t = lt;
            3'b101, 3'b111: t = !lt;
            default:        t = 1'b0;
        endcase
        return {il, t, e, lt};
    endfunction

    // Cycles from accept edge to o_valid.
    function automatic int model_lat(input int inst, input logic [63:0] a,
                                     input logic [63:0] b);
        int n, ch;
        logic [63:0] cmask;
        ch    = chunk_of(inst);
        n     = width_of(inst) / ch;
        cmask = (64'd1 << ch) - 64'd1;
        if (inst == 1) return n;
        for (int k = n - 1; k >= 0; k--) begin
            if (((a >> (k * ch)) & cmask) != ((b >> (k * ch)) & cmask)) return n - k;
        end
        return n;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic run_op(input int inst, input logic [2:0] op, input logic [63:0] a,
                          input logic [63:0] b, input string tag);
        int cyc;
        logic [3:0] e;
        int el;
        exp_q.push_back(model_flags(inst, op, a, b));
        lat_q.push_back(model_lat(inst, a, b));
        cyc = 0;
        while (!rdy[inst] && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        check_val({tag, "_rdy"}, 64'(rdy[inst]), 64'd1);
        f3 = op; rs1 = a; rs2 = b;
        valid_in[inst] = 1'b1;
        @(posedge clk); #1;
        valid_in[inst] = 1'b0;
        cyc = 0;
        while (!vld[inst] && cyc < 40) begin
            @(posedge clk); #1; cyc++;
        end
        e  = exp_q.pop_front();
        el = lat_q.pop_front();
        check_val({tag, "_lat"}, 64'(cyc), 64'(el));
        check_val({tag, "_flags"}, {60'd0, ill[inst], tkn[inst], eq[inst], less[inst]},
                  {60'd0, e});
        check_val({tag, "_st"}, 64'(st[inst]), 64'(DONE));
    endtask

    task automatic release_res(input int inst, input string tag);
        cons_ready = 1'b1;
        @(posedge clk); #1;
        cons_ready = 1'b0;
        check_val({tag, "_rel_vld"}, 64'(vld[inst]), 64'd0);
        check_val({tag, "_rel_rdy"}, 64'(rdy[inst]), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [3:0] held;
        logic [63:0] ra, rb;
        logic [2:0] rop;
        int spurious;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("rst%0d_rdy", i), 64'(rdy[i]), 64'd1);
            check_val($sformatf("rst%0d_vld", i), 64'(vld[i]), 64'd0);
            check_val($sformatf("rst%0d_flags", i),
                      {60'd0, ill[i], tkn[i], eq[i], less[i]}, 64'd0);
            check_val($sformatf("rst%0d_st", i), 64'(st[i]), 64'(IDLE));
        end

        // Directed cases
        run_op(0, 3'b100, 64'hFFFF_FFFF, 64'h1, "blt_m1");
        release_res(0, "blt_m1");
        run_op(0, 3'b110, 64'hFFFF_FFFF, 64'h1, "bltu_m1");
        release_res(0, "bltu_m1");
        run_op(0, 3'b000, 64'h1234_5678, 64'h1234_5678, "beq_eq");
        release_res(0, "beq_eq");
        run_op(0, 3'b101, 64'h10, 64'h11, "bge_low");
        release_res(0, "bge_low");
        run_op(1, 3'b111, 64'hFF00_0000, 64'h0, "bgeu_fix");
        release_res(1, "bgeu_fix");
        run_op(2, 3'b100, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, "blt64");
        release_res(2, "blt64");
        run_op(2, 3'b110, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, "bltu64");
        release_res(2, "bltu64");

        // Backpressure: result must hold while new requests are ignored
        run_op(0, 3'b001, 64'hA5A5_0000, 64'hA5A4_FFFF, "bp");
        held = model_flags(0, 3'b001, 64'hA5A5_0000, 64'hA5A4_FFFF);
        for (int i = 0; i < 5; i++) begin
            rs1 = {$urandom, $urandom};
            rs2 = {$urandom, $urandom};
            f3  = 3'b000;
            valid_in[0] = (i % 2 == 0);
            @(posedge clk); #1;
            check_val($sformatf("bp%0d_flags", i),
                      {60'd0, ill[0], tkn[0], eq[0], less[0]}, {60'd0, held});
            check_val($sformatf("bp%0d_vld", i), 64'(vld[0]), 64'd1);
            check_val($sformatf("bp%0d_rdy", i), 64'(rdy[0]), 64'd0);
        end
        valid_in[0] = 1'b0;
        release_res(0, "bp");
        spurious = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (vld[0] || !rdy[0]) spurious++;
        end
        check_val("bp_no_accept", 64'(spurious), 64'd0);

        // Random traffic on each configuration
        for (int inst = 0; inst < 3; inst++) begin
            for (int k = 0; k < 10; k++) begin
                rop = 3'($urandom_range(0, 7));
                ra  = {$urandom, $urandom};
                case ($urandom_range(0, 2))
                    0:       rb = ra;
                    1:       rb = ra ^ (64'd1 << $urandom_range(0, 63));
                    default: rb = {$urandom, $urandom};
                endcase
                run_op(inst, rop, ra, rb, $sformatf("rnd%0d_%0d", inst, k));
                release_res(inst, $sformatf("rnd%0d_%0d", inst, k));
            end
        end

        // Reset mid-compare: leave nonzero flags first, then abort at idx=2
        run_op(0, 3'b000, 64'h77, 64'h77, "pre_rst");
        release_res(0, "pre_rst");
        f3 = 3'b000; rs1 = 64'h55; rs2 = 64'h55;
        valid_in[0] = 1'b1;
        @(posedge clk); #1;
        valid_in[0] = 1'b0;
        @(posedge clk); #1;
        check_val("mid_st", 64'(st[0]), 64'(CMP));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("mid_rst_vld", 64'(vld[0]), 64'd0);
        check_val("mid_rst_rdy", 64'(rdy[0]), 64'd1);
        check_val("mid_rst_flags", {60'd0, ill[0], tkn[0], eq[0], less[0]}, 64'd0);
        spurious = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (vld[0]) spurious++;
        end
        check_val("mid_rst_no_pulse", 64'(spurious), 64'd0);

        // Illegal funct3 still compares
        run_op(0, 3'b010, 64'd5, 64'd5, "illegal");
        release_res(0, "illegal");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/brc_iter.md
Name: brc_iter

Overview:
Parametrised, multi-cycle branch comparator: successor to the single-cycle combinational branch compare unit. Accepts two WIDTH-bit operands and a RISC-V branch funct3 over a valid/ready handshake. Compares CHUNK bits per cycle from the MSB down, with optional early exit, and returns less/equal/taken flags over a valid/ready handshake. Sits between the operand-read stage and PC-select logic of the multi-cycle and pipelined core variants, where a full-width single-cycle compare is off the critical path budget.

Parameters:
WIDTH, 32, operand width in bits; must be ≥ 2.
CHUNK, 8, bits compared per cycle; WIDTH % CHUNK == 0 (elaboration error otherwise).
EARLY_EXIT, 1, 1 = finish at the first differing chunk; 0 = fixed latency over all chunks.

Ports:
i_clk  in  1  clock; all state updates on rising edge.
i_rst  in  1  synchronous, active-high reset.
i_valid  in  1  request valid.
o_ready  out  1  unit can accept a request (high only in IDLE).
i_rs1_data  in  WIDTH  operand A.
i_rs2_data  in  WIDTH  operand B.
i_funct3  in  3  branch op: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
o_valid  out  1  result valid.
i_ready  in  1  consumer accepts result.
o_br_less  out  1  A < B (signed for BLT/BGE, unsigned for BLTU/BGEU and all other codes).
o_br_equal  out  1  A == B.
o_br_taken  out  1  branch condition true.
o_illegal  out  1  funct3 is 010 or 011.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous, active-high.
- Reset values: state=IDLE, o_valid=0, o_ready=1 from the first cycle after reset, o_br_less=o_br_equal=o_br_taken=o_illegal=0.
- N = WIDTH/CHUNK. Chunk index counter is $clog2(N) bits, minimum 1.
- IDLE:
  - o_ready=1.
  - On i_valid&&o_ready, latch operands and funct3, then go to CMP with idx=N-1.
  - Signed ops invert bit WIDTH-1 of both latched operands, which makes signed compare equal to unsigned compare.
- CMP:
  - o_ready=0. Each cycle compares chunk idx of A and B.
  - If the chunks differ and no difference has been recorded yet, record less = chunk_A < chunk_B (unsigned) and equal=0.
  - EARLY_EXIT=1: on the first difference, go to DONE.
  - Otherwise, at idx==0 go to DONE; if no difference was recorded, equal=1 and less=0. Otherwise idx decrements.
- DONE:
  - o_valid=1; all result outputs stay stable until i_valid-independent handshake o_valid&&i_ready.
  - On the handshake, go to IDLE and drop o_valid the next cycle. No accept happens in the same cycle as result release.
- Latency from the accept edge to o_valid high:
  - EARLY_EXIT=0: N cycles.
  - EARLY_EXIT=1: d+1 cycles, where d = number of equal chunks above the first differing chunk. Equal operands take N cycles.
  - Throughput: one op per latency+2 cycles minimum.
- Taken logic:
  - BEQ=equal, BNE=!equal, BLT/BLTU=less, BGE/BGEU=!less.
  - Illegal funct3: compare still runs unsigned, o_illegal=1, o_br_taken=0.
- Outputs are registered. Result flags outside DONE hold their last values; consumers qualify them with o_valid.
- i_valid while not in IDLE is ignored; the input need not be held.
- Reset in any state, including mid-CMP or DONE with i_ready low: abandon the op, no o_valid pulse, and return to the reset values on the next cycle.
- Boundary cases:
  - Most-negative vs most-positive signed: A=100..0, B=011..1 gives less=1 for BLT and less=0 for BLTU.

Decomposition:
- Shared package brc_pkg:
  - br_op_e enum of the six funct3 codes.
  - brc_state_e {IDLE, CMP, DONE}.
  - Function br_taken(op, less, equal).
- One natural sub-module, brc_chunk_cmp: combinational CHUNK-bit unsigned compare producing lt and eq, instantiated once and indexed by idx.

Test Plan:
1. WIDTH=32, CHUNK=8, EARLY_EXIT=1. BLT with A=0xFFFFFFFF, B=0x00000001 → less=1, equal=0, taken=1; o_valid 1 cycle after accept (MSB chunk differs).
2. Same operands with BLTU → less=0, taken=0, 1-cycle latency. Then BEQ with A=B=0x12345678 → equal=1, taken=1, o_valid 4 cycles after accept.
3. BGE with A=0x00000010, B=0x00000011 → less=1, taken=0, latency 4. Repeat with EARLY_EXIT=0 and A=0xFF000000, B=0x00000000 under BGEU → less=0, taken=1, latency exactly 4.
4. WIDTH=64, CHUNK=16, BLT with A=0x8000000000000000, B=0x7FFFFFFFFFFFFFFF → less=1, taken=1. Same with BLTU → less=0.
5. Backpressure: hold i_ready=0 for 5 cycles in DONE while pulsing i_valid → outputs constant, o_ready=0, no new op accepted. On i_ready=1 → IDLE, o_ready=1 next cycle.
6. Assert i_rst during CMP (idx=2) → next cycle o_valid=0, o_ready=1, all flags 0. Then funct3=010 with A=B=5 → o_illegal=1, equal=1, taken=0.
